noc_pkt_mux: RTL
================

# noc_pkt_mux

Parametrised, packet-aware N:1 flit multiplexer for the NoC router output stage. It generalises the 2:1 combinational mux to NPORT inputs with a registered output and valid/ready back-pressure. It selects inputs either by a static `sel` or by round-robin arbitration, and holds the grant from head flit to tail flit so packets are never interleaved.

## Interface
- NPORT, 2, number of input ports (2..8)
- DATAW, 64, flit payload width
- VCHW, 2, virtual-channel id width
- SELW, 3, width of `sel` (clog2(NPORT), minimum 1)
- Flit word is FLITW = DATAW+2 bits; bits [FLITW-1:FLITW-2] are the type field: 00 NONE, 01 HEAD, 10 DATA, 11 TAIL.

- clk  in  1  clock; all state changes on its rising edge
- rst_  in  1  synchronous active-low reset
- idata  in  NPORT*FLITW  input flits; port p occupies bits [p*FLITW +: FLITW]
- ivalid  in  NPORT  per-port flit valid
- ivch  in  NPORT*VCHW  per-port virtual channel
- iready  out  NPORT  per-port accept; combinational
- mode  in  1  0 = static select via `sel`, 1 = round-robin
- sel  in  SELW  static-mode port index
- odata  out  FLITW  registered output flit
- ovalid  out  1  registered output valid
- ovch  out  VCHW  registered output VC
- oready  in  1  downstream accept
- err  out  1  sticky protocol-error flag
- pkt_cnt  out  16  count of completed packets (tail flits accepted); wraps at 65535

## Operation
- Accept condition for port p: `ivalid[p] & iready[p]`. Output slot free: `space = ~ovalid | oready`.
- FSM states:
  - IDLE: candidates are the ports with ivalid=1 and type HEAD.
    - mode=0: the candidate is `sel`, if that port holds a valid HEAD and sel<NPORT. Otherwise there is no grant.
    - mode=1: the winner is the first candidate searching upward from `rr_ptr`, wrapping modulo NPORT.
    - If there is a winner and space=1, the HEAD is accepted, `gnt` is set to the winner and the FSM goes to LOCKED.
  - LOCKED: only port `gnt` may be accepted, when space=1.
    - Accepting DATA keeps LOCKED.
    - Accepting TAIL goes to IDLE, increments `pkt_cnt` and, in mode 1, sets `rr_ptr = gnt+1` (mod NPORT).
    - Flits of type HEAD or NONE on the locked port are not accepted (iready[gnt]=0) and set `err`.
- iready is high only for the port accepted in the current cycle. All other bits are 0.
- A valid non-HEAD flit on any port in IDLE is not accepted and sets `err`. `err` clears only on reset.
- `mode` and `sel` are sampled only in IDLE. Changing them in LOCKED does not affect the current packet.
- Output register:
  - On accept: odata <= flit, ovch <= ivch of that port, ovalid <= 1.
  - If ovalid & oready and there is no accept: ovalid <= 0, and odata/ovch hold.
- Reset values: ovalid=0, odata=0, ovch=0, err=0, pkt_cnt=0, rr_ptr=0, FSM=IDLE, gnt=0.
- Reset asserted mid-packet discards the held output flit and the lock. Upstream must restart from a HEAD.

## Timing
- Latency: a flit accepted at edge t appears on odata/ovalid after edge t (visible in cycle t+1).
- Throughput: 1 flit/cycle with oready held high. No bubble between a TAIL and the next packet's HEAD: the HEAD may be accepted in the cycle after the TAIL.
- Back-pressure: with ovalid=1 and oready=0, all iready are 0 and the output holds stable until accepted.
- iready depends combinationally on ivalid, idata type, oready, FSM, mode, sel and rr_ptr.
- rr_ptr updates only on TAIL acceptance. A HEAD is granted in the same cycle it is arbitrated.

## Test plan
- NPORT=2, mode=0, sel=1: port1 sends HEAD, 20 DATA, TAIL, then idles 7 cycles; repeat 10 times. Expect 22 flits per packet on odata in order, each one cycle after acceptance, pkt_cnt=10, err=0.
- NPORT=4, mode=1, all ports continuously offering 3-flit packets. Expect grant order 0,1,2,3,0,… with no interleaving inside a packet, and no idle cycle between a TAIL and the next HEAD.
- Back-pressure: oready=0 for 5 cycles mid-packet. Expect ovalid=1 with odata held constant, iready=0 throughout, and no flit lost or duplicated after oready returns to 1.
- Protocol error: a DATA flit on port0 in IDLE, and a HEAD on the locked port during LOCKED. Expect neither accepted, err=1 and sticky, and the locked packet still completes on its TAIL.
- sel change in LOCKED: change sel from 0 to 1 mid-packet. Expect port0's packet to complete, then port1's HEAD to be granted on the next cycle.
- Reset mid-packet: assert rst_=0 for one cycle after 5 flits. Expect all outputs at reset values on the following cycle, FSM in IDLE, and a new HEAD accepted normally afterwards.

Source files
------------

// File: rtl/noc_pkt_mux_if.sv
// Flit bus between upstream ports, the packet mux and the downstream sink.
// The slave view belongs to the mux; the master view belongs to its environment.
interface noc_pkt_mux_if #(
    parameter int unsigned NPORT = 2,
    parameter int unsigned DATAW = 64,
    parameter int unsigned VCHW  = 2
);
    localparam int unsigned FLITW = DATAW + 2;

    logic [NPORT*FLITW-1:0] idata;
    logic [NPORT-1:0]       ivalid;
    logic [NPORT*VCHW-1:0]  ivch;
    logic [NPORT-1:0]       iready;
    logic [FLITW-1:0]       odata;
    logic                   ovalid;
    logic [VCHW-1:0]        ovch;
    logic                   oready;

    modport master (
        output idata, ivalid, ivch, oready,
        input  iready, odata, ovalid, ovch
    );

    modport slave (
        input  idata, ivalid, ivch, oready,
        output iready, odata, ovalid, ovch
    );
endinterface

// File: rtl/noc_pkt_mux.sv
// Packet-aware N:1 flit mux: static or round-robin grant held head-to-tail,
// registered output slot with valid/ready back-pressure.
module noc_pkt_mux #(
    parameter int unsigned NPORT = 2,
    parameter int unsigned DATAW = 64,
    parameter int unsigned VCHW  = 2,
    parameter int unsigned SELW  = 3
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    output logic            err,
    output logic [15:0]     pkt_cnt,
    noc_pkt_mux_if.slave    bus
);
    localparam int unsigned FLITW = DATAW + 2;
    localparam logic [1:0] T_NONE = 2'b00;
    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_DATA = 2'b10;
    localparam logic [1:0] T_TAIL = 2'b11;

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e            state_q, state_d;
    logic [SELW-1:0]   gnt_q, gnt_d;
    logic [SELW-1:0]   rr_q, rr_d;
    logic              lmode_q, lmode_d;
    logic [FLITW-1:0]  odata_q, odata_d;
    logic              ovalid_q, ovalid_d;
    logic [VCHW-1:0]   ovch_q, ovch_d;
    logic              err_q, err_d;
    logic [15:0]       cnt_q, cnt_d;

    logic [1:0]        ftype [NPORT];
    logic [NPORT-1:0]  vhead, vbad;
    logic              rr_hit, st_hit, gnt_valid;
    logic [SELW-1:0]   rr_win;
    logic [1:0]        gnt_type;
    logic              space, acc;
    logic [SELW-1:0]   acc_port;
    logic [FLITW-1:0]  acc_flit;
    logic [VCHW-1:0]   acc_vch;
    logic [NPORT-1:0]  iready_c;

    // Per-port flit classification and both arbitration candidates.
    always_comb begin
        rr_hit    = 1'b0;
        rr_win    = '0;
        st_hit    = 1'b0;
        gnt_valid = 1'b0;
        gnt_type  = T_NONE;
        vhead     = '0;
        vbad      = '0;
        for (int unsigned p = 0; p < NPORT; p++) begin
            ftype[p] = bus.idata[p*FLITW + DATAW +: 2];
            vhead[p] = bus.ivalid[p] && (ftype[p] == T_HEAD);
            vbad[p]  = bus.ivalid[p] && (ftype[p] != T_HEAD);
            if (SELW'(p) == sel && vhead[p]) st_hit = 1'b1;
            if (SELW'(p) == gnt_q) begin
                gnt_valid = bus.ivalid[p];
                gnt_type  = ftype[p];
            end
        end
        // First HEAD at or above rr_q, wrapping.
        for (int unsigned i = 0; i < NPORT; i++) begin
            for (int unsigned p = 0; p < NPORT; p++) begin
                if (!rr_hit && vhead[p] && p == (32'(rr_q) + i) % NPORT) begin
                    rr_hit = 1'b1;
                    rr_win = SELW'(p);
                end
            end
        end
    end

    // Next-state, accept decision and output-slot update.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_d     = rr_q;
        lmode_d  = lmode_q;
        odata_d  = odata_q;
        ovalid_d = ovalid_q;
        ovch_d   = ovch_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        space    = ~ovalid_q | bus.oready;
        acc      = 1'b0;
        acc_port = gnt_q;
        acc_flit = '0;
        acc_vch  = '0;
        iready_c = '0;

        case (state_q)
            IDLE: begin
                if (|vbad) err_d = 1'b1;
                if ((mode ? rr_hit : st_hit) && space) begin
                    acc      = 1'b1;
                    acc_port = mode ? rr_win : sel;
                    gnt_d    = acc_port;
                    lmode_d  = mode;
                    state_d  = LOCKED;
                end
            end
            LOCKED: begin
                if (gnt_valid) begin
                    if (gnt_type == T_DATA || gnt_type == T_TAIL) begin
                        if (space) begin
                            acc = 1'b1;
                            if (gnt_type == T_TAIL) begin
                                state_d = IDLE;
                                cnt_d   = cnt_q + 16'd1;
                                if (lmode_q)
                                    rr_d = (gnt_q == SELW'(NPORT - 1)) ? '0 : gnt_q + SELW'(1);
                            end
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        for (int unsigned p = 0; p < NPORT; p++) begin
            if (acc && SELW'(p) == acc_port) begin
                iready_c[p] = 1'b1;
                acc_flit    = bus.idata[p*FLITW +: FLITW];
                acc_vch     = bus.ivch[p*VCHW +: VCHW];
            end
        end

        if (acc) begin
            odata_d  = acc_flit;
            ovch_d   = acc_vch;
            ovalid_d = 1'b1;
        end else if (ovalid_q && bus.oready) begin
            ovalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rr_q     <= '0;
            lmode_q  <= 1'b0;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
            ovch_q   <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_q     <= rr_d;
            lmode_q  <= lmode_d;
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
            ovch_q   <= ovch_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.iready = iready_c;
    assign bus.odata  = odata_q;
    assign bus.ovalid = ovalid_q;
    assign bus.ovch   = ovch_q;
    assign err        = err_q;
    assign pkt_cnt    = cnt_q;
endmodule
